// File: rtl/lsu_pkg.sv
// Shared definitions for the IOB load/store bridge: FSM state encoding and
// access-size codes used by the bridge top and its alignment datapath.
package lsu_pkg;

    // Bridge FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT_RD = 3'd2,
        RESP    = 3'd3,
        ERR     = 3'd4
    } lsu_state_e;

    // Access size codes as presented on cpu_size_i
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store bridge: byte strobes and store
// lane shift, load extract with sign/zero extension, misalign/illegal-size
// detection. Purely combinational; the bridge registers all results.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int FE_DATA_W = 32,
    localparam int NBYTES_W  = $clog2(FE_DATA_W/8),
    localparam int NB        = FE_DATA_W/8
) (
    input  logic                 we,
    input  logic [1:0]           size,
    input  logic                 uns,
    input  logic [NBYTES_W-1:0]  offset,
    input  logic [FE_DATA_W-1:0] wdata,
    input  logic [FE_DATA_W-1:0] rdata,
    output logic [NB-1:0]        wstrb,
    output logic [FE_DATA_W-1:0] wdata_lane,
    output logic [FE_DATA_W-1:0] rdata_ext,
    output logic                 err
);

    logic [2:0]           off3_s;
    logic [7:0]           mask_s;
    logic [FE_DATA_W-1:0] rd_sh_s;
    logic [63:0]          rd64_s;

    // Offset widened to 3 bits so the dword check works for both data widths
    always_comb begin
        off3_s = 3'(offset);
    end

    // Misalignment and illegal-size detection (dword is illegal on a 32-bit bus)
    always_comb begin
        err = 1'b0;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_H:    err = off3_s[0];
            SZ_W:    err = |off3_s[1:0];
            SZ_D:    err = (FE_DATA_W == 32) ? 1'b1 : (|off3_s);
            default: err = 1'b1;
        endcase
    end

    // Byte-lane mask for the access size, before shifting to the offset
    always_comb begin
        mask_s = 8'h00;
        case (size)
            SZ_B:    mask_s = 8'h01;
            SZ_H:    mask_s = 8'h03;
            SZ_W:    mask_s = 8'h0F;
            SZ_D:    mask_s = 8'hFF;
            default: mask_s = 8'h00;
        endcase
    end

    // Store strobes and lane shift; loads present all-zero strobes
    always_comb begin
        wdata_lane = wdata << {offset, 3'b000};
        if (we) begin
            wstrb = NB'(mask_s) << offset;
        end else begin
            wstrb = '0;
        end
    end

    // Load extract: shift the addressed bytes down, then sign/zero extend
    always_comb begin
        rd_sh_s   = rdata >> {offset, 3'b000};
        rd64_s    = 64'(rd_sh_s);
        rdata_ext = '0;
        case (size)
            SZ_B:    rdata_ext = FE_DATA_W'({{56{~uns & rd64_s[7]}},  rd64_s[7:0]});
            SZ_H:    rdata_ext = FE_DATA_W'({{48{~uns & rd64_s[15]}}, rd64_s[15:0]});
            SZ_W:    rdata_ext = FE_DATA_W'({{32{~uns & rd64_s[31]}}, rd64_s[31:0]});
            SZ_D:    rdata_ext = FE_DATA_W'(rd64_s);
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/iob_lsu_bridge.sv
// CPU memory-stage to IOB cache bridge with sub-word access support.
// One outstanding request; the CPU is stalled until the RESP/ERR cycle.
// Optional build macro LSU_POSTED_WRITE_EN: stores are acknowledged in the
// capture cycle and drain to the cache in the background.
module iob_lsu_bridge
    import lsu_pkg::*;
#(
    parameter  int FE_ADDR_W = 32,
    parameter  int FE_DATA_W = 32,
    localparam int NBYTES_W  = $clog2(FE_DATA_W/8),
    localparam int ADDR_W    = FE_ADDR_W - NBYTES_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_req_valid_i,
    input  logic                   cpu_we_i,
    input  logic [1:0]             cpu_size_i,
    input  logic                   cpu_unsigned_i,
    input  logic [FE_ADDR_W-1:0]   cpu_addr_i,
    input  logic [FE_DATA_W-1:0]   cpu_wdata_i,
    output logic                   cpu_stall_o,
    output logic                   cpu_rvalid_o,
    output logic [FE_DATA_W-1:0]   cpu_rdata_o,
    output logic                   cpu_misalign_o,
    output logic                   iob_valid_o,
    output logic [ADDR_W-1:0]      iob_addr_o,
    output logic [FE_DATA_W-1:0]   iob_wdata_o,
    output logic [FE_DATA_W/8-1:0] iob_wstrb_o,
    input  logic                   iob_ready_i,
    input  logic                   iob_rvalid_i,
    input  logic [FE_DATA_W-1:0]   iob_rdata_i
);

`ifdef LSU_POSTED_WRITE_EN
    localparam logic POSTED_EN = 1'b1;
`else
    localparam logic POSTED_EN = 1'b0;
`endif

    lsu_state_e             state_r, state_n;
    logic [FE_ADDR_W-1:0]   addr_r;
    logic                   we_r;
    logic [1:0]             size_r;
    logic                   uns_r;
    logic [FE_DATA_W-1:0]   wdata_r;
    logic [FE_DATA_W/8-1:0] wstrb_r;
    logic [FE_DATA_W-1:0]   rdata_r;
    logic                   valid_r;
    logic                   rvalid_r;
    logic                   misalign_r;
    logic                   posted_r;

    logic                   sel_cpu_s;
    logic                   cap_s;
    logic                   load_rd_s;
    logic                   ack_s;
    logic [1:0]             a_size_s;
    logic                   a_uns_s;
    logic                   a_we_s;
    logic [NBYTES_W-1:0]    a_off_s;
    logic [FE_DATA_W/8-1:0] al_wstrb_s;
    logic [FE_DATA_W-1:0]   al_wdata_s;
    logic [FE_DATA_W-1:0]   al_rdata_s;
    logic                   al_err_s;

    // Alignment datapath looks at the live CPU request while one can be
    // captured, otherwise at the captured request (for load extraction)
    always_comb begin
        sel_cpu_s = (state_r == IDLE) || ((state_r == REQ) && posted_r);
        if (sel_cpu_s) begin
            a_size_s = cpu_size_i;
            a_uns_s  = cpu_unsigned_i;
            a_we_s   = cpu_we_i;
            a_off_s  = cpu_addr_i[NBYTES_W-1:0];
        end else begin
            a_size_s = size_r;
            a_uns_s  = uns_r;
            a_we_s   = we_r;
            a_off_s  = addr_r[NBYTES_W-1:0];
        end
    end

    lsu_align #(.FE_DATA_W(FE_DATA_W)) u_align (
        .we         (a_we_s),
        .size       (a_size_s),
        .uns        (a_uns_s),
        .offset     (a_off_s),
        .wdata      (cpu_wdata_i),
        .rdata      (iob_rdata_i),
        .wstrb      (al_wstrb_s),
        .wdata_lane (al_wdata_s),
        .rdata_ext  (al_rdata_s),
        .err        (al_err_s)
    );

    // Next-state logic with capture, read-latch and posted-ack strobes
    always_comb begin
        state_n   = state_r;
        cap_s     = 1'b0;
        load_rd_s = 1'b0;
        ack_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu_req_valid_i) begin
                    cap_s = 1'b1;
                    if (al_err_s) begin
                        state_n = ERR;
                    end else begin
                        state_n = REQ;
                        ack_s   = POSTED_EN & cpu_we_i;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                if (iob_ready_i) begin
                    if (posted_r) begin
                        // Posted store accepted: take the waiting request now
                        if (cpu_req_valid_i) begin
                            cap_s = 1'b1;
                            if (al_err_s) begin
                                state_n = ERR;
                            end else begin
                                state_n = REQ;
                                ack_s   = POSTED_EN & cpu_we_i;
                            end
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (we_r) begin
                        state_n = RESP;
                    end else if (iob_rvalid_i) begin
                        load_rd_s = 1'b1;
                        state_n   = RESP;
                    end else begin
                        state_n = WAIT_RD;
                    end
                end else begin
                    state_n = REQ;
                end
            end
            WAIT_RD: begin
                if (iob_rvalid_i) begin
                    load_rd_s = 1'b1;
                    state_n   = RESP;
                end else begin
                    state_n = WAIT_RD;
                end
            end
            RESP:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, capture and registered output flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            we_r       <= 1'b0;
            size_r     <= 2'd0;
            uns_r      <= 1'b0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            rdata_r    <= '0;
            valid_r    <= 1'b0;
            rvalid_r   <= 1'b0;
            misalign_r <= 1'b0;
            posted_r   <= 1'b0;
        end else begin
            state_r    <= state_n;
            valid_r    <= (state_n == REQ);
            rvalid_r   <= (state_n == RESP) || (state_n == ERR);
            misalign_r <= (state_n == ERR);
            rdata_r    <= load_rd_s ? al_rdata_s : '0;
            if (cap_s) begin
                addr_r   <= cpu_addr_i;
                we_r     <= cpu_we_i;
                size_r   <= cpu_size_i;
                uns_r    <= cpu_unsigned_i;
                wdata_r  <= al_wdata_s;
                wstrb_r  <= al_wstrb_s;
                posted_r <= ack_s;
            end else begin
                posted_r <= posted_r && (state_n == REQ);
            end
        end
    end

    // Output drive; stall/ack are gated by reset so everything reads 0 in reset
    always_comb begin
        cpu_stall_o    = reset_n & cpu_req_valid_i & (state_r != RESP) &
                         (state_r != ERR) & ~ack_s;
        cpu_rvalid_o   = rvalid_r | (reset_n & ack_s);
        cpu_rdata_o    = rdata_r;
        cpu_misalign_o = misalign_r;
        iob_valid_o    = valid_r;
        iob_addr_o     = addr_r[FE_ADDR_W-1:NBYTES_W];
        iob_wdata_o    = wdata_r;
        iob_wstrb_o    = wstrb_r;
    end

endmodule

// File: tb/tb_iob_lsu_bridge.sv
// Directed, table-driven bench for iob_lsu_bridge (default 32-bit build).
module tb_iob_lsu_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req_valid_i, cpu_we_i, cpu_unsigned_i;
    logic [1:0]  cpu_size_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic        cpu_stall_o, cpu_rvalid_o, cpu_misalign_o;
    logic [31:0] cpu_rdata_o;
    logic        iob_valid_o;
    logic [29:0] iob_addr_o;
    logic [31:0] iob_wdata_o;
    logic [3:0]  iob_wstrb_o;
    logic        iob_ready_i, iob_rvalid_i;
    logic [31:0] iob_rdata_i;

    int ncmp = 0;
    int nfail = 0;

    iob_lsu_bridge dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req_valid_i(cpu_req_valid_i), .cpu_we_i(cpu_we_i),
        .cpu_size_i(cpu_size_i), .cpu_unsigned_i(cpu_unsigned_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_stall_o(cpu_stall_o), .cpu_rvalid_o(cpu_rvalid_o),
        .cpu_rdata_o(cpu_rdata_o), .cpu_misalign_o(cpu_misalign_o),
        .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o),
        .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
        .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i(iob_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          rdy;    // cycles iob_ready_i held low in REQ
        int          rv;     // WAIT_RD cycles until iob_rvalid_i (0 = same cycle)
        logic        err;
        logic [29:0] eaddr;
        logic [3:0]  estrb;
        logic [31:0] ewdata;
        logic [31:0] erdata;
    } vec_t;

    function automatic vec_t mk(logic we, logic [1:0] sz, logic uns, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] rd, int rdy, int rv,
                                logic err, logic [29:0] ea, logic [3:0] es,
                                logic [31:0] ewd, logic [31:0] erd);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd; v.rd = rd;
        v.rdy = rdy; v.rv = rv; v.err = err; v.eaddr = ea; v.estrb = es;
        v.ewdata = ewd; v.erdata = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Apply one request and follow it to its response, acting as the cache
    task automatic run_vec(input vec_t v, input string nm);
        int  c = 0;
        int  vcnt = 0;
        int  rcnt = 0;
        bit  seen_v = 1'b0;
        bit  done = 1'b0;
        @(negedge clk);
        cpu_req_valid_i = 1'b1; cpu_we_i = v.we; cpu_size_i = v.size;
        cpu_unsigned_i = v.uns; cpu_addr_i = v.addr; cpu_wdata_i = v.wdata;
        iob_rdata_i = v.rd; iob_ready_i = 1'b0; iob_rvalid_i = 1'b0;
        #1 chk({nm, " idle stall"}, 64'(cpu_stall_o), 64'd1);
        while (!done && c < 60) begin
            @(posedge clk); #1; c++;
            if (cpu_rvalid_o) begin
                done = 1'b1;
                chk({nm, " latency"}, 64'(c + 1), v.err ? 64'd2 : 64'(3 + v.rdy + v.rv));
                chk({nm, " misalign"}, 64'(cpu_misalign_o), 64'(v.err));
                chk({nm, " rdata"}, 64'(cpu_rdata_o), 64'(v.erdata));
                chk({nm, " resp stall"}, 64'(cpu_stall_o), 64'd0);
                chk({nm, " iob access"}, 64'(seen_v), 64'(!v.err));
                cpu_req_valid_i = 1'b0; iob_ready_i = 1'b0; iob_rvalid_i = 1'b0;
                @(posedge clk); #1;
                chk({nm, " rvalid pulse"}, 64'(cpu_rvalid_o), 64'd0);
                chk({nm, " rdata idle"}, 64'(cpu_rdata_o), 64'd0);
            end else if (iob_valid_o) begin
                seen_v = 1'b1;
                chk({nm, " addr"}, 64'(iob_addr_o), 64'(v.eaddr));
                chk({nm, " wstrb"}, 64'(iob_wstrb_o), 64'(v.estrb));
                chk({nm, " wdata"}, 64'(iob_wdata_o), 64'(v.ewdata));
                chk({nm, " req stall"}, 64'(cpu_stall_o), 64'd1);
                vcnt++;
                if (vcnt > v.rdy) begin
                    iob_ready_i  = 1'b1;
                    iob_rvalid_i = !v.we && (v.rv == 0);
                end else begin
                    iob_ready_i  = 1'b0;
                    iob_rvalid_i = 1'b0;
                end
            end else begin
                iob_ready_i = 1'b0;
                rcnt++;
                iob_rvalid_i = (rcnt >= v.rv);
                chk({nm, " wait stall"}, 64'(cpu_stall_o), 64'd1);
            end
        end
        if (!done) begin
            ncmp++; nfail++;
            $display("FAIL %s timeout: no cpu_rvalid_o within 60 cycles", nm);
            cpu_req_valid_i = 1'b0; iob_ready_i = 1'b0; iob_rvalid_i = 1'b0;
        end
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = mk(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 30'h40, 4'hF, 32'hDEADBEEF, 32'h0);
        tbl[1]  = mk(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0, 0, 1'b0, 30'h40, 4'h8, 32'hA5000000, 32'h0);
        tbl[2]  = mk(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h12F03456, 0, 0, 1'b0, 30'h40, 4'h0, 32'h0, 32'hFFFFFFF0);
        tbl[3]  = mk(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 32'h12F03456, 0, 0, 1'b0, 30'h40, 4'h0, 32'h0, 32'h000000F0);
        tbl[4]  = mk(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h12F03456, 0, 0, 1'b1, 30'h0, 4'h0, 32'h0, 32'h0);
        tbl[5]  = mk(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h12F03456, 0, 0, 1'b1, 30'h0, 4'h0, 32'h0, 32'h0);
        tbl[6]  = mk(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 4, 2, 1'b0, 30'h80, 4'h0, 32'h0, 32'hCAFEF00D);
        tbl[7]  = mk(1'b1, 2'd1, 1'b0, 32'h10A, 32'h00001234, 32'h0, 0, 0, 1'b0, 30'h42, 4'hC, 32'h12340000, 32'h0);
        tbl[8]  = mk(1'b0, 2'd1, 1'b0, 32'h106, 32'h0, 32'h80017FFF, 0, 0, 1'b0, 30'h41, 4'h0, 32'h0, 32'hFFFF8001);
        tbl[9]  = mk(1'b0, 2'd1, 1'b1, 32'h106, 32'h0, 32'h80017FFF, 1, 0, 1'b0, 30'h41, 4'h0, 32'h0, 32'h00008001);
        tbl[10] = mk(1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h80000000, 1, 1, 1'b0, 30'h3FFFFFFF, 4'h0, 32'h0, 32'h80000000);
        tbl[11] = mk(1'b1, 2'd2, 1'b0, 32'h102, 32'h11223344, 32'h0, 0, 0, 1'b1, 30'h0, 4'h0, 32'h0, 32'h0);
        tbl[12] = mk(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h00007F00, 0, 3, 1'b0, 30'h40, 4'h0, 32'h0, 32'h0000007F);
        tbl[13] = mk(1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFFFF77, 32'h0, 2, 0, 1'b0, 30'h40, 4'h2, 32'hFFFF7700, 32'h0);

        reset_n = 1'b0;
        cpu_req_valid_i = 1'b0; cpu_we_i = 1'b0; cpu_size_i = 2'd0; cpu_unsigned_i = 1'b0;
        cpu_addr_i = 32'h0; cpu_wdata_i = 32'h0;
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = 32'h0;
        #12;
        chk("reset valid", 64'(iob_valid_o), 64'd0);
        chk("reset rvalid", 64'(cpu_rvalid_o), 64'd0);
        chk("reset rdata", 64'(cpu_rdata_o), 64'd0);
        chk("reset misalign", 64'(cpu_misalign_o), 64'd0);
        chk("reset addr", 64'(iob_addr_o), 64'd0);
        chk("reset wstrb", 64'(iob_wstrb_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while REQ is pending: the IOB request must drop at once
        @(negedge clk);
        cpu_req_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_size_i = 2'd2; cpu_addr_i = 32'h300;
        iob_ready_i = 1'b0; iob_rvalid_i = 1'b0;
        @(posedge clk); #1;
        chk("rst-req valid before", 64'(iob_valid_o), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst-req valid", 64'(iob_valid_o), 64'd0);
        chk("rst-req stall", 64'(cpu_stall_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset during WAIT_RD: everything reads 0 immediately
        @(posedge clk); #1;
        chk("rst-wr valid in REQ", 64'(iob_valid_o), 64'd1);
        iob_ready_i = 1'b1;
        @(posedge clk); #1;
        iob_ready_i = 1'b0;
        chk("rst-wr valid in WAIT_RD", 64'(iob_valid_o), 64'd0);
        chk("rst-wr stall in WAIT_RD", 64'(cpu_stall_o), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst-wr valid", 64'(iob_valid_o), 64'd0);
        chk("rst-wr stall", 64'(cpu_stall_o), 64'd0);
        chk("rst-wr rvalid", 64'(cpu_rvalid_o), 64'd0);
        @(negedge clk);
        cpu_req_valid_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        run_vec(mk(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0BADF00D, 0, 1, 1'b0, 30'hC0, 4'h0, 32'h0, 32'h0BADF00D), "post-reset LW");

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/iob_lsu_bridge.md
Name: iob_lsu_bridge

Overview:
- Parametrised successor of the CPU-to-cache adapter.
- Explicit request/stall handshake to the pipelined CPU's memory stage; IOB front-end protocol towards iob_cache_iob.
- Adds sub-word loads/stores (byte lane strobes, sign/zero extension), misalignment detection and configurable data width.
- Sits between pl_riscv_cpu and iob_cache_iob inside the front-end top.

Parameters:
- FE_ADDR_W, 32, CPU byte-address width
- FE_DATA_W, 32, data width; 32 or 64 only
- NBYTES_W, $clog2(FE_DATA_W/8), derived byte-offset width; localparam, not overridable
- ADDR_W, FE_ADDR_W-NBYTES_W, word-address width to cache; localparam

Ports:
- clk  in  1  clock (single clock domain)
- reset_n  in  1  asynchronous, active-low reset
- cpu_req_valid_i  in  1  memory-stage request present
- cpu_we_i  in  1  1=store, 0=load
- cpu_size_i  in  2  0=byte, 1=half, 2=word, 3=dword
- cpu_unsigned_i  in  1  zero-extend load (LBU/LHU/LWU)
- cpu_addr_i  in  FE_ADDR_W  byte address
- cpu_wdata_i  in  FE_DATA_W  store data, LSB-aligned
- cpu_stall_o  out  1  freeze pipeline
- cpu_rvalid_o  out  1  response cycle (load data or store done)
- cpu_rdata_o  out  FE_DATA_W  extended load data
- cpu_misalign_o  out  1  access-fault pulse
- iob_valid_o  out  1  IOB request
- iob_addr_o  out  ADDR_W  word address
- iob_wdata_o  out  FE_DATA_W  lane-shifted store data
- iob_wstrb_o  out  FE_DATA_W/8  byte strobes; all-zero = read
- iob_ready_i  in  1  cache accepted request
- iob_rvalid_i  in  1  read data valid
- iob_rdata_i  in  FE_DATA_W  read data

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; capture registers 0. Asserting reset mid-transaction drops iob_valid_o immediately; the request is abandoned.
- States:
  - IDLE: on cpu_req_valid_i, capture addr/we/size/unsigned/wdata. Misaligned or illegal size -> ERR, else -> REQ.
  - REQ: iob_valid_o=1, address/strobes held stable until iob_ready_i. Then store -> RESP; load -> RESP if iob_rvalid_i is high the same cycle, else WAIT_RD.
  - WAIT_RD: wait for iob_rvalid_i, latch data -> RESP.
  - RESP: cpu_rvalid_o=1 for exactly one cycle -> IDLE.
  - ERR: cpu_misalign_o=1 and cpu_rvalid_o=1 for one cycle, cpu_rdata_o=0, no IOB access -> IDLE.
- cpu_stall_o = cpu_req_valid_i & (state != RESP) & (state != ERR); combinational. The CPU advances on the RESP/ERR edge.
- Minimum latency:
  - store with iob_ready_i=1: 3 cycles (IDLE, REQ, RESP);
  - load with same-cycle rvalid: 3 cycles;
  - otherwise +1 cycle per wait.
- Alignment: misaligned when addr[size-1:0] != 0 for size>=1. size=3 with FE_DATA_W=32 is illegal -> ERR.
- Stores: iob_wstrb_o = ((1<<(1<<size))-1) << addr[NBYTES_W-1:0]; iob_wdata_o = cpu_wdata_i << (8*offset).
- Loads: iob_wstrb_o=0. Data = iob_rdata_i >> (8*offset), truncated to the access size, then sign- or zero-extended to FE_DATA_W. Full-width loads pass through unchanged.
- cpu_rdata_o is registered, valid only while cpu_rvalid_o=1, and 0 otherwise.
- A new cpu_req_valid_i is sampled only in IDLE; requests are never queued or dropped silently.

Optional Feature:
- Macro: LSU_POSTED_WRITE_EN.
- Defined: a store in IDLE releases stall in the capture cycle (cpu_rvalid_o pulses, state -> REQ) and drains to the cache in the background. A following request while REQ is still pending stalls until the store is accepted; that request is then captured in the same cycle iob_ready_i is seen.
- Undefined: stores are fully blocking as described above.

Decomposition:
- Package lsu_pkg holds:
  - state encoding localparams (IDLE, REQ, WAIT_RD, RESP, ERR);
  - size codes SZ_B/SZ_H/SZ_W/SZ_D.
- Sub-module lsu_align: combinational strobe generation, store lane shift, load extract/extend, misalign detect; instantiated once.

Test Plan:
- SW 0xDEADBEEF to 0x100, iob_ready_i=1 -> iob_addr_o=0x40, wstrb=4'b1111, wdata=0xDEADBEEF, stall high 2 cycles, rvalid pulse on 3rd.
- SB 0x000000A5 to 0x103 -> wstrb=4'b1000, wdata=0xA5000000.
- LB at 0x102 with iob_rdata_i=0x12F03456 -> cpu_rdata_o=0xFFFFFFF0. LBU, same address -> 0x000000F0.
- LH at 0x101 -> cpu_misalign_o pulse, no iob_valid_o, rdata=0. Size 3 with FE_DATA_W=32 -> same.
- LW with iob_ready_i low 4 cycles, then rvalid 2 cycles later -> iob_valid_o/addr held stable, stall throughout, single rvalid pulse with correct data.
- reset_n low during WAIT_RD -> iob_valid_o, cpu_stall_o, cpu_rvalid_o all 0 immediately. After release, a new LW completes normally.
